// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared definitions for the pulse_meter block.
//   state_e     - measurement FSM encodings (3-bit)
//   PulseCountW - width of the accepted-pulse counter
//   cnt_max()   - all-ones value of a measurement counter of a given width
// Optional build macro used by the block: PULSE_METER_FILTER_EN.
package pulse_meter_pkg;

    typedef enum logic [2:0] {
        StFlush = 3'd0,
        StSkip  = 3'd1,
        StArmed = 3'd2,
        StHigh  = 3'd3,
        StLow   = 3'd4
    } state_e;

    localparam int unsigned PulseCountW = 16;

    // Saturation value of a w-bit measurement counter.
    function automatic logic [63:0] cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// pulse_meter_sync_edge: the sync_edge stage of pulse_meter.
// Brings the asynchronous pulse line into the clock domain, optionally
// glitch-filters it, and detects rising/falling edges of the result.
// Build macro: PULSE_METER_FILTER_EN adds a FILT_LEN-sample stability filter.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset
//   pulse_in - asynchronous pulse line
//   level    - synchronized (filtered when enabled) level
//   rise     - level went 0->1 this cycle
//   fall     - level went 1->0 this cycle
module pulse_meter_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pulse_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   s_d_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PULSE_METER_FILTER_EN
    localparam int unsigned    FiltCntW = $clog2(FILT_LEN + 1);
    localparam logic [FiltCntW-1:0] FiltLast = FiltCntW'(FILT_LEN - 1);

    logic                filt_q, filt_d;
    logic [FiltCntW-1:0] fcnt_q, fcnt_d;

    // Flip only after FILT_LEN consecutive samples disagree with the held level;
    // any agreeing sample restarts the run.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FiltLast) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + FiltCntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign s = filt_q;
`else
    logic unused_filt_len;
    assign unused_filt_len = ^FILT_LEN;
    assign s = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign level = s;
    assign rise  = s & ~s_d_q;
    assign fall  = ~s & s_d_q;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high width and rise-to-rise period of an asynchronous
// pulse line in clock cycles, counts accepted pulses and strobes each completed
// measurement for one cycle.
// Build macro: PULSE_METER_FILTER_EN enables the input glitch filter.
// Ports:
//   clock       - system clock, rising edge
//   reset       - synchronous active-high reset
//   pulse_in    - asynchronous pulse line
//   level       - synchronized (filtered when enabled) level of pulse_in
//   width       - high time of last completed pulse
//   period      - rise-to-rise time of last completed pulse
//   meas_valid  - one-cycle strobe, width/period updated
//   pulse_count - accepted rising edges, wraps
//   overflow    - sticky, a measurement counter saturated
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pulse_in,
    output logic                   level,
    output logic [CNT_W-1:0]       width,
    output logic [CNT_W-1:0]       period,
    output logic                   meas_valid,
    output logic [PulseCountW-1:0] pulse_count,
    output logic                   overflow
);

    // Flush long enough for reset-time zeros to drain out of the input pipeline,
    // so the first decision is made on a real sample of pulse_in.
`ifdef PULSE_METER_FILTER_EN
    localparam int unsigned FlushLen = SYNC_STAGES + 1 + FILT_LEN;
`else
    localparam int unsigned FlushLen = SYNC_STAGES + 1;
`endif
    localparam int unsigned          FlushCntW = $clog2(FlushLen);
    localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FlushLen - 1);
    localparam logic [CNT_W-1:0]     CntMax    = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0]     CntOne    = CNT_W'(1);

    logic s_level, rise, fall;

    pulse_meter_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_edge (
        .clock    (clock),
        .reset    (reset),
        .pulse_in (pulse_in),
        .level    (s_level),
        .rise     (rise),
        .fall     (fall)
    );

    state_e                 state_q, state_d;
    logic [FlushCntW-1:0]   flush_q, flush_d;
    logic [CNT_W-1:0]       wc_q, wc_d;
    logic [CNT_W-1:0]       pc_q, pc_d;
    logic [CNT_W-1:0]       width_hold_q, width_hold_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   mv_q, mv_d;
    logic [PulseCountW-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       wc_inc, pc_inc;

    assign wc_inc = (wc_q == CntMax) ? wc_q : wc_q + CntOne;
    assign pc_inc = (pc_q == CntMax) ? pc_q : pc_q + CntOne;

    always_comb begin
        state_d      = state_q;
        flush_d      = flush_q;
        wc_d         = wc_q;
        pc_d         = pc_q;
        width_hold_d = width_hold_q;
        width_d      = width_q;
        period_d     = period_q;
        mv_d         = 1'b0;
        count_d      = count_q;
        ovf_d        = ovf_q;

        unique case (state_q)
            StFlush: begin
                if (flush_q == FlushLast) begin
                    state_d = s_level ? StSkip : StArmed;
                end else begin
                    flush_d = flush_q + FlushCntW'(1);
                end
            end
            // A pulse already high at start-up has an unknown width; wait it out.
            StSkip: begin
                if (fall) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (rise) begin
                    state_d = StHigh;
                    count_d = count_q + PulseCountW'(1);
                    wc_d    = CntOne;
                    pc_d    = CntOne;
                end
            end
            StHigh: begin
                pc_d = pc_inc;
                if (fall) begin
                    width_hold_d = wc_q;
                    state_d      = StLow;
                end else begin
                    wc_d = wc_inc;
                end
            end
            StLow: begin
                if (rise) begin
                    width_d  = width_hold_q;
                    period_d = pc_q;
                    mv_d     = 1'b1;
                    count_d  = count_q + PulseCountW'(1);
                    wc_d     = CntOne;
                    pc_d     = CntOne;
                    state_d  = StHigh;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = StFlush;
            end
        endcase

        if ((wc_d == CntMax) || (pc_d == CntMax)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StFlush;
            flush_q      <= '0;
            wc_q         <= '0;
            pc_q         <= '0;
            width_hold_q <= '0;
            width_q      <= '0;
            period_q     <= '0;
            mv_q         <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            wc_q         <= wc_d;
            pc_q         <= pc_d;
            width_hold_q <= width_hold_d;
            width_q      <= width_d;
            period_q     <= period_d;
            mv_q         <= mv_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    assign level       = s_level;
    assign width       = width_q;
    assign period      = period_q;
    assign meas_valid  = mv_q;
    assign pulse_count = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed self-checking bench for pulse_meter (CNT_W=8,
// SYNC_STAGES=2, FILT_LEN=2). Expectations for the glitch and toggle cases
// follow PULSE_METER_FILTER_EN when the bench is built with it.
module tb_pulse_meter;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        pulse_in = 1'b0;
    logic        level;
    logic [7:0]  width;
    logic [7:0]  period;
    logic        meas_valid;
    logic [15:0] pulse_count;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;

    // Strobe monitor: counts strobes, captures reported values, flags back-to-back strobes.
    int   strobes = 0;
    int   last_w  = 0;
    int   last_p  = 0;
    int   b2b     = 0;
    logic prev_mv = 1'b0;
    int   s0;

    pulse_meter #(
        .CNT_W       (8),
        .SYNC_STAGES (2),
        .FILT_LEN    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .level       (level),
        .width       (width),
        .period      (period),
        .meas_valid  (meas_valid),
        .pulse_count (pulse_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (meas_valid === 1'b1) begin
            strobes <= strobes + 1;
            last_w  <= int'(width);
            last_p  <= int'(period);
            if (prev_mv === 1'b1) begin
                b2b <= b2b + 1;
            end
        end
        prev_mv <= meas_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        pulse_in = v;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        pulse_in = 1'b0;
        tick(3);
        check("rst_level", 32'(level), 0);
        check("rst_width", 32'(width), 0);
        check("rst_period", 32'(period), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_pulse_count", 32'(pulse_count), 0);
        check("rst_overflow", 32'(overflow), 0);

        // 1: 6/6 stream, four pulses
        reset = 1'b0;
        drive(1'b0, 8);
        s0 = strobes;
        drive(1'b1, 6);
        check("t1_level_high", 32'(level), 1);
        check("t1_no_strobe_first_rise", 32'(strobes - s0), 0);
        check("t1_count_first", 32'(pulse_count), 1);
        drive(1'b0, 6);
        check("t1_level_low", 32'(level), 0);
        repeat (3) begin
            drive(1'b1, 6);
            drive(1'b0, 6);
        end
        check("t1_strobes", 32'(strobes - s0), 3);
        check("t1_width", 32'(last_w), 6);
        check("t1_period", 32'(last_p), 12);
        check("t1_count", 32'(pulse_count), 4);
        check("t1_no_overflow", 32'(overflow), 0);

        // 2: pulse high across reset release is skipped, then a 3/5 pulse
        reset = 1'b1;
        pulse_in = 1'b1;
        tick(3);
        reset = 1'b0;
        drive(1'b1, 10);
        check("t2_partial_not_counted", 32'(pulse_count), 0);
        drive(1'b0, 5);
        drive(1'b1, 3);
        drive(1'b0, 5);
        check("t2_count_first_full", 32'(pulse_count), 1);
        s0 = strobes;
        drive(1'b1, 6);
        drive(1'b0, 6);
        check("t2_strobes", 32'(strobes - s0), 1);
        check("t2_width", 32'(last_w), 3);
        check("t2_period", 32'(last_p), 8);

        // 3: 300-cycle pulse saturates an 8-bit counter
        reset = 1'b1;
        pulse_in = 1'b0;
        tick(2);
        reset = 1'b0;
        drive(1'b0, 8);
        drive(1'b1, 300);
        check("t3_overflow_set", 32'(overflow), 1);
        drive(1'b0, 10);
        s0 = strobes;
        drive(1'b1, 6);
        drive(1'b0, 6);
        check("t3_strobes", 32'(strobes - s0), 1);
        check("t3_width_sat", 32'(last_w), 255);
        check("t3_period_sat", 32'(last_p), 255);
        drive(1'b1, 6);
        drive(1'b0, 6);
        drive(1'b1, 6);
        drive(1'b0, 6);
        check("t3_width_after", 32'(last_w), 6);
        check("t3_period_after", 32'(last_p), 12);
        check("t3_overflow_sticky", 32'(overflow), 1);
        reset = 1'b1;
        tick(1);
        check("t3_overflow_cleared", 32'(overflow), 0);

        // 4: reset during HIGH of pulse 2
        reset = 1'b0;
        drive(1'b0, 8);
        drive(1'b1, 6);
        drive(1'b0, 6);
        drive(1'b1, 5);
        check("t4_pre_width", 32'(width), 6);
        check("t4_pre_count", 32'(pulse_count), 2);
        reset = 1'b1;
        tick(1);
        check("t4_rst_width", 32'(width), 0);
        check("t4_rst_period", 32'(period), 0);
        check("t4_rst_count", 32'(pulse_count), 0);
        check("t4_rst_level", 32'(level), 0);
        check("t4_rst_meas_valid", 32'(meas_valid), 0);
        pulse_in = 1'b0;
        tick(1);
        check("t4_no_stale_strobe", 32'(meas_valid), 0);
        reset = 1'b0;
        drive(1'b0, 8);
        s0 = strobes;
        drive(1'b1, 6);
        check("t4_restart_count", 32'(pulse_count), 1);
        drive(1'b0, 6);
        drive(1'b1, 6);
        drive(1'b0, 6);
        check("t4_count", 32'(pulse_count), 2);
        check("t4_strobes", 32'(strobes - s0), 1);
        check("t4_width", 32'(last_w), 6);
        check("t4_period", 32'(last_p), 12);

        // 5: pulse_in toggling every clock
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        drive(1'b0, 8);
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            drive((i % 2) == 0, 1);
        end
        drive(1'b0, 6);
`ifdef PULSE_METER_FILTER_EN
        check("t5_strobes", 32'(strobes - s0), 0);
        check("t5_count", 32'(pulse_count), 0);
`else
        check("t5_strobes", 32'(strobes - s0), 9);
        check("t5_width", 32'(last_w), 1);
        check("t5_period", 32'(last_p), 2);
        check("t5_count", 32'(pulse_count), 10);
`endif

        // 6: one-cycle glitch between 6/6 pulses
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        drive(1'b0, 8);
        s0 = strobes;
        drive(1'b1, 6);
        drive(1'b0, 6);
        drive(1'b1, 6);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 3);
        drive(1'b1, 6);
`ifdef PULSE_METER_FILTER_EN
        check("t6_strobes", 32'(strobes - s0), 2);
        check("t6_width", 32'(last_w), 6);
        check("t6_period", 32'(last_p), 12);
        check("t6_count", 32'(pulse_count), 3);
`else
        check("t6_strobes", 32'(strobes - s0), 3);
        check("t6_glitch_width", 32'(last_w), 1);
        check("t6_glitch_period", 32'(last_p), 4);
        check("t6_count", 32'(pulse_count), 4);
`endif
        drive(1'b0, 6);
        drive(1'b1, 6);
        drive(1'b0, 6);
        check("t6_width_after", 32'(last_w), 6);
        check("t6_period_after", 32'(last_p), 12);

        check("no_back_to_back_strobe", 32'(b2b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
